// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that programs instruction memory while holding the CPU
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    // Largest legal word count; a full memory (2^ADDR_WIDTH words) is allowed.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [7:0]  len_lo;
    logic [16:0] len_rx;
    logic [16:0] word_total;
    logic [16:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [7:0]  run_xor;
    logic [31:0] shift_word;
    logic        accept;
    logic        start_ok;
    logic        last_word;

    // Handshake and status are pure decodes of the current state.
    assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CHECK);
    assign imem_we    = (state == S_WRITE);
    assign cpu_hold   = byte_ready || (state == S_WRITE) || (state == S_ERR);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERR);

    assign accept     = byte_valid && byte_ready;
    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // Full 16-bit length as it would be latched by the LEN_HI byte currently on the bus.
    assign len_rx     = {1'b0, byte_data, len_lo};

    // The word counter is one bit wider than the address so a full-memory load
    // terminates on the count rather than on an address that wrapped to zero.
    assign last_word  = ((word_cnt + 17'd1) == word_total);

    assign imem_addr  = word_cnt[ADDR_WIDTH-1:0];
    assign imem_wdata = shift_word;

    // Frame sequencing: length, data words with a write slot after each, checksum.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    next_state = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    next_state = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (len_rx > MAX_WORDS) begin
                        next_state = S_ERR;
                    end else if (len_rx == 17'd0) begin
                        next_state = S_CHECK;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (byte_cnt == 2'd3)) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                next_state = last_word ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (accept) begin
                    next_state = (byte_data == run_xor) ? S_DONE : S_ERR;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the 16-bit word count from the two length bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo     <= 8'd0;
            word_total <= 17'd0;
        end else if (start_ok) begin
            word_total <= 17'd0;
        end else if (accept && (state == S_LEN_LO)) begin
            len_lo <= byte_data;
        end else if (accept && (state == S_LEN_HI)) begin
            word_total <= len_rx;
        end
    end

    // Running XOR over every frame byte ahead of the checksum byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_xor <= 8'd0;
        end else if (start_ok) begin
            run_xor <= 8'd0;
        end else if (accept && (state != S_CHECK)) begin
            run_xor <= run_xor ^ byte_data;
        end
    end

    // Little-endian word assembly: each new byte enters at the top, so byte 0 ends in bits 7:0.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_word <= 32'd0;
            byte_cnt   <= 2'd0;
        end else if (start_ok) begin
            byte_cnt <= 2'd0;
        end else if (accept && (state == S_DATA)) begin
            shift_word <= {byte_data, shift_word[31:8]};
            byte_cnt   <= byte_cnt + 2'd1;
        end
    end

    // Word address: starts at zero on each load and advances once per write slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt <= 17'd0;
        end else if (start_ok) begin
            word_cnt <= 17'd0;
        end else if (state == S_WRITE) begin
            word_cnt <= word_cnt + 17'd1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_xfer = 0;
    int clash  = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [31:0]   exp_words[$];
    logic [7:0]    frame[$];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Observe memory writes and byte transfers mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
        if (byte_valid && byte_ready) n_xfer++;
        if (imem_we && byte_ready) clash++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        n_xfer = 0;
        clash  = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Frame from the word list: length, little-endian words, XOR of all preceding bytes.
    function automatic void build_frame();
        logic [15:0] n16;
        logic [7:0]  x;
        logic [31:0] w;
        n16 = 16'(exp_words.size());
        frame.delete();
        frame.push_back(n16[7:0]);
        frame.push_back(n16[15:8]);
        for (int i = 0; i < exp_words.size(); i++) begin
            w = exp_words[i];
            for (int b = 0; b < 4; b++) frame.push_back(w[8*b +: 8]);
        end
        x = 8'd0;
        for (int i = 0; i < frame.size(); i++) x = x ^ frame[i];
        frame.push_back(x);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit sent;
        int budget;
        sent = 1'b0;
        budget = 100;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                tick();
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!sent && budget > 0) begin
            @(negedge clk);
            sent = byte_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        if (!sent) begin
            total++;
            bad++;
            $display("FAIL send_byte_timeout byte=%02h ready=%0b want ready=1", b, byte_ready);
        end
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i < hi; i++) send_byte(frame[i], gaps);
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (3) tick();
        total++;
        if ({byte_ready, imem_we, cpu_hold, done, error} !== 5'b0 || imem_addr !== '0 || imem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_values got=%b addr=%0h wdata=%0h want=00000 addr=0 wdata=0",
                     {byte_ready, imem_we, cpu_hold, done, error}, imem_addr, imem_wdata);
        end
        reset = 1'b0;
        repeat (2) tick();
        total++;
        if ({byte_ready, imem_we, cpu_hold, done, error} !== 5'b0) begin
            bad++;
            $display("FAIL idle_after_reset got=%b want=00000", {byte_ready, imem_we, cpu_hold, done, error});
        end
    endtask

    task automatic test_two_word();
        int t0;
        frame = '{8'h02, 8'h00, 8'h21, 8'h04, 8'h00, 8'h91, 8'hC0, 8'h03, 8'h1F, 8'hD6, 8'hBC};
        clear_mon();
        do_start();
        t0 = cyc;
        total++;
        if (byte_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL start_latency got ready=%0b hold=%0b want ready=1 hold=1", byte_ready, cpu_hold);
        end
        send_range(0, frame.size(), 1'b0);
        total++;
        if (cyc - t0 !== 13) begin
            bad++;
            $display("FAIL two_word_cycles got=%0d want=13", cyc - t0);
        end
        total++;
        if (wr_addr_q.size() !== 2) begin
            bad++;
            $display("FAIL two_word_write_count got=%0d want=2", wr_addr_q.size());
        end else begin
            total++;
            if (wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'h91000421) begin
                bad++;
                $display("FAIL two_word_w0 got=%0h:%08h want=0:91000421", wr_addr_q[0], wr_data_q[0]);
            end
            total++;
            if (wr_addr_q[1] !== 10'd1 || wr_data_q[1] !== 32'hD61F03C0) begin
                bad++;
                $display("FAIL two_word_w1 got=%0h:%08h want=1:d61f03c0", wr_addr_q[1], wr_data_q[1]);
            end
        end
        total++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            bad++;
            $display("FAIL two_word_status got done,error,hold=%b want=100", {done, error, cpu_hold});
        end
    endtask

    task automatic test_zero_len();
        int t0;
        frame = '{8'h00, 8'h00, 8'h00};
        clear_mon();
        do_start();
        t0 = cyc;
        send_range(0, frame.size(), 1'b0);
        total++;
        if (wr_addr_q.size() !== 0 || cyc - t0 !== 3) begin
            bad++;
            $display("FAIL zero_len_writes got writes=%0d cycles=%0d want writes=0 cycles=3",
                     wr_addr_q.size(), cyc - t0);
        end
        total++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            bad++;
            $display("FAIL zero_len_status got done,error,hold=%b want=100", {done, error, cpu_hold});
        end
    endtask

    task automatic test_bad_chk();
        frame = '{8'h02, 8'h00, 8'h21, 8'h04, 8'h00, 8'h91, 8'hC0, 8'h03, 8'h1F, 8'hD6, 8'hBD};
        clear_mon();
        do_start();
        send_range(0, frame.size(), 1'b0);
        total++;
        if (wr_addr_q.size() !== 2) begin
            bad++;
            $display("FAIL bad_chk_write_count got=%0d want=2", wr_addr_q.size());
        end else begin
            total++;
            if (wr_data_q[0] !== 32'h91000421 || wr_data_q[1] !== 32'hD61F03C0) begin
                bad++;
                $display("FAIL bad_chk_data got=%08h,%08h want=91000421,d61f03c0", wr_data_q[0], wr_data_q[1]);
            end
        end
        total++;
        if ({done, error, cpu_hold} !== 3'b011) begin
            bad++;
            $display("FAIL bad_chk_status got done,error,hold=%b want=011", {done, error, cpu_hold});
        end
        do_start();
        total++;
        if ({done, error, cpu_hold, byte_ready} !== 4'b0011) begin
            bad++;
            $display("FAIL restart_after_err got done,error,hold,ready=%b want=0011",
                     {done, error, cpu_hold, byte_ready});
        end
        frame = '{8'h00, 8'h00, 8'h00};
        send_range(0, frame.size(), 1'b0);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL restart_completes got done=%0b want=1", done);
        end
    endtask

    task automatic test_oversize();
        frame = '{8'h01, 8'h04};
        clear_mon();
        do_start();
        send_range(0, frame.size(), 1'b0);
        total++;
        if ({error, done, byte_ready, cpu_hold} !== 4'b1001 || wr_addr_q.size() !== 0) begin
            bad++;
            $display("FAIL oversize got error,done,ready,hold=%b writes=%0d want=1001 writes=0",
                     {error, done, byte_ready, cpu_hold}, wr_addr_q.size());
        end
    endtask

    task automatic test_ignored_start();
        frame = '{8'h02, 8'h00, 8'h21, 8'h04, 8'h00, 8'h91, 8'hC0, 8'h03, 8'h1F, 8'hD6, 8'hBC};
        clear_mon();
        do_start();
        send_range(0, 4, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (byte_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start_state got ready=%0b hold=%0b done=%0b want 1,1,0", byte_ready, cpu_hold, done);
        end
        send_range(4, frame.size(), 1'b0);
        total++;
        if (wr_data_q.size() !== 2 || done !== 1'b1) begin
            bad++;
            $display("FAIL ignored_start_result got writes=%0d done=%0b want writes=2 done=1", wr_data_q.size(), done);
        end else begin
            total++;
            if (wr_data_q[0] !== 32'h91000421 || wr_data_q[1] !== 32'hD61F03C0 || wr_addr_q[1] !== 10'd1) begin
                bad++;
                $display("FAIL ignored_start_data got=%08h,%08h a1=%0h want=91000421,d61f03c0 a1=1",
                         wr_data_q[0], wr_data_q[1], wr_addr_q[1]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        frame = '{8'h02, 8'h00, 8'h21, 8'h04, 8'h00, 8'h91, 8'hC0, 8'h03, 8'h1F, 8'hD6, 8'hBC};
        clear_mon();
        do_start();
        send_range(0, 5, 1'b0);
        byte_valid = 1'b1;
        byte_data  = frame[5];
        reset = 1'b1;
        tick();
        reset = 1'b0;
        byte_valid = 1'b0;
        total++;
        if ({byte_ready, imem_we, cpu_hold, done, error} !== 5'b0 || imem_addr !== '0 || imem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_load got=%b addr=%0h wdata=%08h want=00000 addr=0 wdata=0",
                     {byte_ready, imem_we, cpu_hold, done, error}, imem_addr, imem_wdata);
        end
        repeat (6) tick();
        total++;
        if (wr_addr_q.size() !== 0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_load_writes got writes=%0d hold=%0b want writes=0 hold=0", wr_addr_q.size(), cpu_hold);
        end
    endtask

    task automatic test_backpressure();
        for (int f = 0; f < 8; f++) begin
            int  n;
            bit  corrupt;
            int  mism;
            exp_words.delete();
            if (f == 0) begin
                exp_words.push_back(32'h91000421);
                exp_words.push_back(32'hD61F03C0);
            end else begin
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) exp_words.push_back($urandom);
            end
            corrupt = (f % 3 == 2);
            build_frame();
            if (corrupt) frame[frame.size()-1] = frame[frame.size()-1] ^ (8'h01 << $urandom_range(0, 7));
            clear_mon();
            do_start();
            send_range(0, frame.size(), 1'b1);
            mism = 0;
            for (int i = 0; i < wr_data_q.size() && i < exp_words.size(); i++) begin
                if (wr_data_q[i] !== exp_words[i] || wr_addr_q[i] !== AW'(i)) mism++;
            end
            total++;
            if (wr_data_q.size() !== exp_words.size() || mism !== 0) begin
                bad++;
                $display("FAIL bp_writes frame=%0d got count=%0d mism=%0d want count=%0d mism=0",
                         f, wr_data_q.size(), mism, exp_words.size());
            end
            total++;
            if (n_xfer !== frame.size() || clash !== 0) begin
                bad++;
                $display("FAIL bp_transfers frame=%0d got xfer=%0d clash=%0d want xfer=%0d clash=0",
                         f, n_xfer, clash, frame.size());
            end
            total++;
            if ({done, error, cpu_hold} !== (corrupt ? 3'b011 : 3'b100)) begin
                bad++;
                $display("FAIL bp_status frame=%0d got done,error,hold=%b want=%b",
                         f, {done, error, cpu_hold}, (corrupt ? 3'b011 : 3'b100));
            end
        end
    endtask

    task automatic test_full_capacity();
        int t0;
        int mism;
        exp_words.delete();
        for (int i = 0; i < (1 << AW); i++) exp_words.push_back($urandom);
        build_frame();
        clear_mon();
        do_start();
        t0 = cyc;
        send_range(0, frame.size(), 1'b0);
        mism = 0;
        for (int i = 0; i < wr_data_q.size() && i < exp_words.size(); i++) begin
            if (wr_data_q[i] !== exp_words[i] || wr_addr_q[i] !== AW'(i)) mism++;
        end
        total++;
        if (wr_data_q.size() !== (1 << AW) || mism !== 0) begin
            bad++;
            $display("FAIL full_writes got count=%0d mism=%0d want count=%0d mism=0", wr_data_q.size(), mism, 1 << AW);
        end else begin
            total++;
            if (wr_addr_q[(1 << AW) - 1] !== {AW{1'b1}}) begin
                bad++;
                $display("FAIL full_last_addr got=%0h want=%0h", wr_addr_q[(1 << AW) - 1], {AW{1'b1}});
            end
        end
        total++;
        if ({done, error, cpu_hold} !== 3'b100 || cyc - t0 !== 3 + 5 * (1 << AW)) begin
            bad++;
            $display("FAIL full_status got done,error,hold=%b cycles=%0d want=100 cycles=%0d",
                     {done, error, cpu_hold}, cyc - t0, 3 + 5 * (1 << AW));
        end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_zero_len();
        test_bad_chk();
        test_oversize();
        test_ignored_start();
        test_reset_mid_load();
        test_backpressure();
        test_full_capacity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
